// File: rtl/bridge_pkg.sv
// bridge_pkg: state codes, motor drive codes and the moving-state predicate for bridge_actuator.
package bridge_pkg;
  typedef enum logic [2:0] {
    ST_ROAD_OPEN    = 3'b000,
    ST_BAR_LOWERING = 3'b001,
    ST_BAR_DOWN     = 3'b010,
    ST_BR_RAISING   = 3'b011,
    ST_BR_UP        = 3'b100,
    ST_BR_LOWERING  = 3'b101,
    ST_BAR_RAISING  = 3'b110,
    ST_FAULT        = 3'b111
  } state_t;
  typedef enum logic [1:0] {
    MOT_OFF   = 2'b00,
    MOT_LOWER = 2'b01,
    MOT_RAISE = 2'b10
  } motor_t;
  function automatic logic is_moving(input state_t s);
    return s inside {ST_BAR_LOWERING, ST_BR_RAISING, ST_BR_LOWERING, ST_BAR_RAISING};
  endfunction
endpackage

// File: rtl/bridge_actuator_move_timer.sv
// move_timer: saturating per-move cycle counter; expired flags the last allowed cycle of a move.
module move_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
  assign expired = en && cnt == LAST;
endmodule

// File: rtl/bridge_actuator.sv
// bridge_actuator: Moore FSM sequencing barrier and bridge motors with interlock and move timeouts.
// Optional LIMIT_SYNC_EN adds 2-flop synchronizers on the four limit switch inputs.
module bridge_actuator
  import bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_carBarrier,
  input  logic       i_bridge_s,
  input  logic       i_alert,
  input  logic       i_faultClr,
  input  logic       i_barrierUp,
  input  logic       i_barrierDown,
  input  logic       i_bridgeUp,
  input  logic       i_bridgeDown,
  output logic [1:0] o_barrierMotor,
  output logic [1:0] o_bridgeMotor,
  output logic       o_fault,
  output logic       o_roadOpen,
  output logic [2:0] o_state
);
  logic [3:0] lim;
`ifdef LIMIT_SYNC_EN
  logic [3:0] sync1, sync2;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {i_barrierUp, i_barrierDown, i_bridgeUp, i_bridgeDown};
      sync2 <= sync1;
    end
  assign lim = sync2;
`else
  assign lim = {i_barrierUp, i_barrierDown, i_bridgeUp, i_bridgeDown};
`endif
  logic bar_up, bar_dn, br_up, br_dn, expired;
  assign {bar_up, bar_dn, br_up, br_dn} = lim;
  state_t state, nxt;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) state <= ST_ROAD_OPEN;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (state != ST_FAULT && ((bar_up && bar_dn) || (br_up && br_dn))) nxt = ST_FAULT;
    else if (expired) nxt = ST_FAULT;
    else
      case (state)
        ST_ROAD_OPEN:    nxt = !br_dn ? ST_FAULT : i_carBarrier ? ST_BAR_LOWERING : state;
        ST_BAR_LOWERING: nxt = !i_carBarrier ? ST_BAR_RAISING : bar_dn ? ST_BAR_DOWN : state;
        ST_BAR_DOWN:     nxt = (i_bridge_s && !i_alert) ? ST_BR_RAISING :
                               (!i_carBarrier && !i_bridge_s) ? ST_BAR_RAISING : state;
        ST_BR_RAISING:   nxt = !bar_dn ? ST_FAULT : !i_bridge_s ? ST_BR_LOWERING : br_up ? ST_BR_UP : state;
        ST_BR_UP:        nxt = !bar_dn ? ST_FAULT : !i_bridge_s ? ST_BR_LOWERING : state;
        ST_BR_LOWERING:  nxt = br_dn ? ST_BAR_DOWN : state;
        ST_BAR_RAISING:  nxt = i_carBarrier ? ST_BAR_LOWERING : bar_up ? ST_ROAD_OPEN : state;
        ST_FAULT:        nxt = !i_faultClr ? state : (br_dn && bar_dn) ? ST_BAR_DOWN :
                               (br_dn && bar_up) ? ST_ROAD_OPEN : state;
        default:         nxt = ST_FAULT;
      endcase
  end
  always_comb begin
    o_barrierMotor = state == ST_BAR_LOWERING ? MOT_LOWER : state == ST_BAR_RAISING ? MOT_RAISE : MOT_OFF;
    o_bridgeMotor  = state == ST_BR_LOWERING ? MOT_LOWER : state == ST_BR_RAISING ? MOT_RAISE : MOT_OFF;
    o_fault        = state == ST_FAULT;
    o_roadOpen     = state == ST_ROAD_OPEN;
    o_state        = state;
  end
  // Any state change restarts the move timer, including the transition into FAULT on expiry.
  move_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(i_clk),
    .rst_n(i_reset),
    .clr(nxt != state),
    .en(is_moving(state)),
    .expired(expired)
  );
endmodule
